// File: rtl/rv32i_pkg.sv
// Shared rv32i pipeline constants and types.
// The fetch state encoding lives here so every stage agrees on it.
package rv32i_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register.
// Update priority is flush, then stall (hold), then load; with no load it inserts a bubble.
module if_id_reg
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            stall,
    input  logic            load,
    input  logic [31:0]     loadInstr,
    input  logic [XLEN-1:0] loadPc,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            validD
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            validD   <= 1'b0;
        end else if (flush) begin
            // PCD/PCPlus4D keep their old values; only the instruction is squashed.
            InstrD <= NOP_INSTR;
            validD <= 1'b0;
        end else if (!stall) begin
            if (load) begin
                InstrD   <= loadInstr;
                PCD      <= loadPc;
                PCPlus4D <= loadPc + XLEN'(4);
                validD   <= 1'b1;
            end else begin
                InstrD <= NOP_INSTR;
                validD <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request FSM, and a one-entry skid buffer.
// The skid buffer absorbs a response that lands while decode is stalled.
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stallF,
    input  logic            stallD,
    input  logic            flushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            validD
);

    fetch_state_t    stateReg, stateNext;
    logic [XLEN-1:0] pcF, pcFNext;
    logic [XLEN-1:0] reqAddr, reqAddrNext;
    logic            killReg, killNext;
    logic            skidValid;
    logic [31:0]     skidInstr;
    logic [XLEN-1:0] skidPc;

    logic            respDone;
    logic            accepted;
    logic            skidLoad;
    logic            skidDrain;

    // reqAddr freezes the presented address so a redirect cannot disturb a pending request.
    assign imem_req  = (stateReg == REQ);
    assign imem_addr = (stateReg == REQ) ? reqAddr : pcF;

    always_comb begin
        stateNext   = stateReg;
        killNext    = killReg;
        pcFNext     = pcF;
        reqAddrNext = reqAddr;

        respDone  = (stateReg == WAIT) && imem_rvalid;
        accepted  = respDone && !killReg && !PCSrcE;
        skidLoad  = accepted && stallD;
        skidDrain = skidValid && !flushD && !stallD;

        if (PCSrcE) begin
            pcFNext = PCTargetE;
        end else if (accepted) begin
            pcFNext = pcF + XLEN'(4);
        end

        if (PCSrcE && ((stateReg == REQ) || ((stateReg == WAIT) && !imem_rvalid))) begin
            killNext = 1'b1;
        end else if (respDone) begin
            killNext = 1'b0;
        end

        // A response that completes goes straight back to REQ, giving one fetch per two cycles.
        case (stateReg)
            IDLE: begin
                if (!stallF && (!skidValid || PCSrcE)) begin
                    stateNext   = REQ;
                    reqAddrNext = pcFNext;
                end
            end
            REQ: begin
                if (imem_gnt) begin
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (!stallF && !skidLoad) begin
                        stateNext   = REQ;
                        reqAddrNext = pcFNext;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= IDLE;
            pcF      <= RESET_PC;
            reqAddr  <= RESET_PC;
            killReg  <= 1'b0;
        end else begin
            stateReg <= stateNext;
            pcF      <= pcFNext;
            reqAddr  <= reqAddrNext;
            killReg  <= killNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skidValid <= 1'b0;
            skidInstr <= NOP_INSTR;
            skidPc    <= '0;
        end else if (PCSrcE) begin
            skidValid <= 1'b0;
        end else if (skidLoad) begin
            skidValid <= 1'b1;
            skidInstr <= imem_rdata;
            skidPc    <= reqAddr;
        end else if (skidDrain) begin
            skidValid <= 1'b0;
        end
    end

    // The skid buffer and a fresh response are mutually exclusive: no request issues while it is full.
    if_id_reg #(
        .XLEN(XLEN)
    ) u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flushD),
        .stall    (stallD),
        .load     (skidValid || accepted),
        .loadInstr(skidValid ? skidInstr : imem_rdata),
        .loadPc   (skidValid ? skidPc : reqAddr),
        .InstrD   (InstrD),
        .PCD      (PCD),
        .PCPlus4D (PCPlus4D),
        .validD   (validD)
    );

endmodule
